// File: rtl/nibble_serial_adder.sv
// Multi-precision add/subtract sequencer: one 4-bit ripple adder reused over
// WIDTH/4 nibbles, LS nibble first, with a registered inter-nibble carry.

module ripple_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             msb_l_q, msb_r_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [3:0]       add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] full_sum;
  logic             accept, last;

  ripple_adder_4bit u_adder (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (add_sum),
    .cout (add_cout)
  );

  assign accept = start_valid && (state_q == IDLE);
  assign last   = (cnt_q == LAST);

  // Partial nibbles collect separately so sum keeps the previous result
  // until the final nibble lands.
  generate
    if (NIBBLES == 1) begin : g_single
      assign full_sum = add_sum;
    end else begin : g_multi
      logic [WIDTH-5:0] acc_q;
      assign full_sum = {add_sum, acc_q};
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          acc_q <= '0;
        else if (state_q == RUN)
          acc_q <= full_sum[WIDTH-1:4];
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state_q == IDLE) && !reset;
    result_valid = (state_q == DONE);
    busy         = (state_q != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      msb_l_q <= 1'b0;
      msb_r_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= left;
      b_q     <= subtract ? ~right : right;
      carry_q <= subtract ? 1'b1 : carry_in;
      cnt_q   <= '0;
      msb_l_q <= left[WIDTH-1];
      msb_r_q <= subtract ? ~right[WIDTH-1] : right[WIDTH-1];
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      carry_q <= add_cout;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        sum_q  <= full_sum;
        cout_q <= add_cout;
        ovf_q  <= (msb_l_q == msb_r_q) && (add_sum[3] != msb_l_q);
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of nibble_serial_adder (WIDTH=16) against
// an arithmetic reference model.

module tb_nibble_serial_adder;
  logic        clock = 1'b0;
  logic        reset;
  logic        start_valid, start_ready;
  logic [15:0] left, right;
  logic        carry_in, subtract;
  logic        result_valid, result_ready;
  logic [15:0] sum;
  logic        carry_out, overflow, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .left         (left),
    .right        (right),
    .carry_in     (carry_in),
    .subtract     (subtract),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [15:0] l, input logic [15:0] r, input logic cin,
                       input logic sub, output logic [15:0] s, output logic co,
                       output logic ov);
    int ul, ur, t, sl, sr, sv;
    ul = l;
    ur = r;
    sl = $signed(l);
    sr = $signed(r);
    if (sub) begin
      t  = ul - ur;
      co = (ul >= ur);
      sv = sl - sr;
    end else begin
      t  = ul + ur + int'(cin);
      co = (t > 65535);
      sv = sl + sr + int'(cin);
    end
    s  = 16'(t);
    ov = (sv > 32767) || (sv < -32768);
  endtask

  task automatic scramble();
    left        = 16'($urandom);
    right       = 16'($urandom);
    carry_in    = 1'($urandom);
    subtract    = 1'($urandom);
    start_valid = 1'($urandom);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!start_ready && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    check("ready_before_start", start_ready, 1);
  endtask

  task automatic do_op(input logic [15:0] l, input logic [15:0] r, input logic cin,
                       input logic sub, input int stall);
    logic [15:0] es;
    logic        eco, eov;
    model(l, r, cin, sub, es, eco, eov);
    wait_ready();
    left = l; right = r; carry_in = cin; subtract = sub; start_valid = 1'b1;
    @(posedge clock); #1;
    check("busy_after_accept", busy, 1);
    check("start_ready_run", start_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      scramble();
      @(posedge clock); #1;
      check("valid_timing", result_valid, 32'(k == 4));
      check("busy_run", busy, 1);
    end
    check("sum", sum, es);
    check("carry_out", carry_out, eco);
    check("overflow", overflow, eov);
    for (int k = 0; k < stall; k++) begin
      scramble();
      @(posedge clock); #1;
      check("stall_valid", result_valid, 1);
      check("stall_sum", sum, es);
      check("stall_start_ready", start_ready, 0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(posedge clock); #1;
    result_ready = 1'b0;
    check("drained_valid", result_valid, 0);
    check("drained_busy", busy, 0);
    check("drained_start_ready", start_ready, 1);
    check("idle_sum_kept", sum, es);
  endtask

  initial begin
    reset = 1'b1;
    start_valid = 1'b0; result_ready = 1'b0;
    left = '0; right = '0; carry_in = 1'b0; subtract = 1'b0;
    #1;
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, 0);
    check("rst_ovf", overflow, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1 check("post_rst_start_ready", start_ready, 1);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 2);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 10);
    do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0);

    // Reset pulsed in the second RUN cycle, between clock edges.
    wait_ready();
    left = 16'h4444; right = 16'h2222; carry_in = 1'b0; subtract = 1'b0; start_valid = 1'b1;
    @(posedge clock); #1;
    start_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("abort_valid", result_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_carry", carry_out, 0);
    check("abort_ovf", overflow, 0);
    #1 reset = 1'b0;
    #1 check("abort_start_ready", start_ready, 1);
    @(posedge clock); #1;
    do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] l, r;
      l = 16'($urandom);
      r = 16'($urandom);
      if (n % 8 == 0) l = 16'h8000;
      if (n % 8 == 1) r = 16'h7FFF;
      if (n % 8 == 2) l = 16'hFFFF;
      do_op(l, r, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
